mcht_trx_os: RTL and testbench



---
 rtl/mcht_trx_os.sv | 175 +++++++++++++++++
 tb/tb_mcht_trx_os.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mcht_trx_os.sv
// Oversampled Manchester transceiver on one clock: framed encoder (preamble,
// SFD, payload, even parity, IFG) and edge-timed decoder with error reporting.
module mcht_trx_os #(
  parameter int pTX_MSG_LEN = 16,
  parameter int pRX_MSG_LEN = 16,
  parameter int pOSR        = 8,
  parameter int pPRE        = 4,
  parameter int pPRE_MIN    = 2,
  parameter int pIFG        = 2
) (
  input  logic                   CLK100M,
  input  logic                   RST_N,
  output logic                   TXD,
  input  logic                   RXD,
  input  logic                   TX_VLD,
  output logic                   TX_RDY,
  input  logic [pTX_MSG_LEN-1:0] TX_MSG,
  output logic                   TX_DNE,
  output logic [pRX_MSG_LEN-1:0] RX_MSG,
  output logic                   RX_VLD,
  output logic                   RX_ERR
);
  localparam int MLEN0  = (pTX_MSG_LEN > pRX_MSG_LEN) ? pTX_MSG_LEN : pRX_MSG_LEN;
  localparam int MLEN   = (MLEN0 > pPRE) ? MLEN0 : pPRE;
  localparam int BW     = $clog2(MLEN + 2);
  localparam int CW     = $clog2(2 * pOSR);
  localparam int PW     = $clog2(pOSR);
  localparam logic [CW-1:0] EARLY = CW'(3 * pOSR / 4);
  localparam logic [CW-1:0] LATE  = CW'(5 * pOSR / 4);

  // ---------------- transmitter ----------------
  typedef enum logic [2:0] {TX_IDLE, TX_PRE, TX_SFD, TX_DATA, TX_PAR, TX_IFG} tx_state_t;
  tx_state_t tx_state, tx_next;
  logic [PW-1:0]          tx_ph;
  logic [BW-1:0]          tx_bits;
  logic [pTX_MSG_LEN-1:0] tx_sh;
  logic                   tx_par, tx_bit, bit_end;

  assign bit_end = (tx_ph == PW'(pOSR - 1));

  always_ff @(posedge CLK100M or negedge RST_N)
    if (!RST_N) tx_state <= TX_IDLE;
    else        tx_state <= tx_next;

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE: if (TX_VLD) tx_next = TX_PRE;
      TX_PRE:  if (bit_end && tx_bits == BW'(pPRE - 1)) tx_next = TX_SFD;
      TX_SFD:  if (bit_end) tx_next = TX_DATA;
      TX_DATA: if (bit_end && tx_bits == BW'(pTX_MSG_LEN - 1)) tx_next = TX_PAR;
      TX_PAR:  if (bit_end) tx_next = TX_IFG;
      TX_IFG:  if (bit_end && tx_bits == BW'(pIFG - 1)) tx_next = TX_IDLE;
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge CLK100M or negedge RST_N)
    if (!RST_N) begin
      tx_ph   <= '0;
      tx_bits <= '0;
      tx_sh   <= '0;
      tx_par  <= 1'b0;
    end else if (tx_state == TX_IDLE) begin
      tx_ph   <= '0;
      tx_bits <= '0;
      if (TX_VLD) begin
        tx_sh  <= TX_MSG;
        tx_par <= ^TX_MSG;
      end
    end else if (bit_end) begin
      tx_ph   <= '0;
      tx_bits <= (tx_next != tx_state) ? '0 : tx_bits + BW'(1);
      if (tx_state == TX_DATA) tx_sh <= tx_sh << 1;
    end else begin
      tx_ph <= tx_ph + PW'(1);
    end

  always_comb begin
    TX_RDY = (tx_state == TX_IDLE);
    TX_DNE = (tx_state == TX_IFG) && bit_end && (tx_bits == BW'(pIFG - 1));
    case (tx_state)
      TX_SFD:  tx_bit = 1'b0;
      TX_DATA: tx_bit = tx_sh[pTX_MSG_LEN-1];
      TX_PAR:  tx_bit = tx_par;
      default: tx_bit = 1'b1;
    endcase
    if (tx_state == TX_IDLE || tx_state == TX_IFG) TXD = 1'b0;
    else TXD = (tx_ph < PW'(pOSR / 2)) ? ~tx_bit : tx_bit;
  end

  // ---------------- receiver ----------------
  typedef enum logic [1:0] {RX_HUNT, RX_PRE, RX_DATA} rx_state_t;
  rx_state_t rx_state, rx_next;
  logic                   rx_s1, rx_s2, rx_s3;
  logic [CW-1:0]          cnt;
  logic [BW-1:0]          pre_cnt, rx_bits;
  logic [pRX_MSG_LEN-1:0] rx_sh;
  logic rx_edge, armed, mid, tmo, last_bit, par_ok, vld_d, err_d;

  assign rx_edge  = rx_s2 ^ rx_s3;
  assign armed    = (cnt >= CW'(pOSR));
  assign mid      = rx_edge && (cnt >= EARLY) && (cnt <= LATE);
  assign tmo      = (cnt > LATE);
  assign last_bit = (rx_bits == BW'(pRX_MSG_LEN));
  assign par_ok   = ~(^rx_sh ^ rx_s2);

  always_ff @(posedge CLK100M or negedge RST_N)
    if (!RST_N) rx_state <= RX_HUNT;
    else        rx_state <= rx_next;

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_HUNT: if (rx_edge && rx_s2 && armed) rx_next = RX_PRE;
      RX_PRE: begin
        if (tmo) rx_next = RX_HUNT;
        else if (mid && !rx_s2) rx_next = (pre_cnt >= BW'(pPRE_MIN)) ? RX_DATA : RX_HUNT;
      end
      RX_DATA: if (tmo || (mid && last_bit)) rx_next = RX_HUNT;
      default: rx_next = RX_HUNT;
    endcase
  end

  always_comb begin
    vld_d = 1'b0;
    err_d = 1'b0;
    if (rx_state == RX_DATA) begin
      vld_d = mid && last_bit && par_ok;
      err_d = tmo || (mid && last_bit && !par_ok);
    end
  end

  // In HUNT, cnt measures the idle-low run; elsewhere it times bits, with the
  // accepting edge cycle itself counted as 0 so the next nominal mid-edge sits at pOSR.
  always_ff @(posedge CLK100M or negedge RST_N)
    if (!RST_N) begin
      rx_s1   <= 1'b0;
      rx_s2   <= 1'b0;
      rx_s3   <= 1'b0;
      cnt     <= '0;
      pre_cnt <= '0;
      rx_bits <= '0;
      rx_sh   <= '0;
      RX_MSG  <= '0;
      RX_VLD  <= 1'b0;
      RX_ERR  <= 1'b0;
    end else begin
      rx_s1  <= RXD;
      rx_s2  <= rx_s1;
      rx_s3  <= rx_s2;
      RX_VLD <= vld_d;
      RX_ERR <= err_d;
      if (vld_d) RX_MSG <= rx_sh;
      if (rx_state == RX_HUNT) begin
        pre_cnt <= BW'(1);
        rx_bits <= '0;
        if (rx_next == RX_PRE) cnt <= CW'(1);
        else if (rx_s2)        cnt <= '0;
        else if (!armed)       cnt <= cnt + CW'(1);
      end else if (rx_next == RX_HUNT) begin
        cnt <= '0;
      end else if (mid) begin
        cnt <= CW'(1);
        if (rx_state == RX_PRE) begin
          if (rx_s2 && pre_cnt != '1) pre_cnt <= pre_cnt + BW'(1);
        end else begin
          rx_bits <= rx_bits + BW'(1);
          if (!last_bit) rx_sh <= {rx_sh[pRX_MSG_LEN-2:0], rx_s2};
        end
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
endmodule

// File: tb/tb_mcht_trx_os.sv
// Directed bench for mcht_trx_os: loopback and line-model frames, received
// payloads checked against a queue of expected messages.
module tb_mcht_trx_os;
  localparam int OSR  = 8;
  localparam int HALF = OSR / 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        txd, rxd, rxd_m, loop;
  logic        tx_vld, tx_rdy, tx_dne, rx_vld, rx_err;
  logic [15:0] tx_msg, rx_msg;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int both_seen = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];

  assign rxd = loop ? txd : rxd_m;

  mcht_trx_os dut (
    .CLK100M(clk), .RST_N(rst_n), .TXD(txd), .RXD(rxd),
    .TX_VLD(tx_vld), .TX_RDY(tx_rdy), .TX_MSG(tx_msg), .TX_DNE(tx_dne),
    .RX_MSG(rx_msg), .RX_VLD(rx_vld), .RX_ERR(rx_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_vld) got_q.push_back(rx_msg);
    if (rx_err) err_seen++;
    if (rx_vld && rx_err) both_seen++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int jv(input logic jit);
    return jit ? int'($urandom_range(2)) - 1 : 0;
  endfunction

  task automatic send_bit(input logic b, input int j);
    rxd_m = ~b; repeat (HALF + j) @(negedge clk);
    rxd_m = b;  repeat (HALF - j) @(negedge clk);
  endtask

  task automatic send_frame(input logic [15:0] msg, input int npre, input logic pinv, input logic jit);
    rxd_m = 1'b0; repeat (2 * OSR) @(negedge clk);
    for (int i = 0; i < npre; i++) send_bit(1'b1, jv(jit));
    send_bit(1'b0, jv(jit));
    for (int i = 15; i >= 0; i--) send_bit(msg[i], jv(jit));
    send_bit((^msg) ^ pinv, jv(jit));
    rxd_m = 1'b0; repeat (3 * OSR) @(negedge clk);
  endtask

  // Leaves the caller in the acceptance cycle with TX_VLD raised.
  task automatic tx_accept(input logic [15:0] msg);
    int n = 0;
    while (!tx_rdy && n < 500) begin @(negedge clk); n++; end
    check("tx_rdy_wait", {31'd0, tx_rdy}, 32'd1);
    tx_msg = msg;
    tx_vld = 1'b1;
  endtask

  task automatic expect_rx(input string tag);
    int n = 0;
    logic [15:0] e;
    while (got_q.size() == 0 && n < 400) begin @(negedge clk); n++; end
    check({tag, "_present"}, {31'd0, got_q.size() != 0}, 32'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    if (got_q.size() != 0) check(tag, {16'd0, got_q.pop_front()}, {16'd0, e});
  endtask

  initial begin
    int n, acc2, e0, v0;
    logic p1, p2;
    rst_n = 1'b0; tx_vld = 1'b0; tx_msg = '0; rxd_m = 1'b0; loop = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_txd",    {31'd0, txd},    32'd0);
    check("rst_tx_rdy", {31'd0, tx_rdy}, 32'd1);
    check("rst_tx_dne", {31'd0, tx_dne}, 32'd0);
    check("rst_rx_msg", {16'd0, rx_msg}, 32'd0);
    check("rst_rx_vld", {31'd0, rx_vld}, 32'd0);
    check("rst_rx_err", {31'd0, rx_err}, 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Basic loopback, A5C3 (P=0): DNE at acceptance+192, RDY back at +193
    e0 = err_seen;
    tx_accept(16'hA5C3); exp_q.push_back(16'hA5C3);
    @(negedge clk); tx_vld = 1'b0;
    repeat (190) @(negedge clk);
    check("dne_191", {31'd0, tx_dne}, 32'd0);
    @(negedge clk);
    check("dne_192", {31'd0, tx_dne}, 32'd1);
    check("rdy_192", {31'd0, tx_rdy}, 32'd0);
    @(negedge clk);
    check("rdy_193", {31'd0, tx_rdy}, 32'd1);
    expect_rx("basic_msg");
    check("basic_no_err", 32'(err_seen - e0), 32'd0);

    // Back-to-back with TX_VLD held; TX_MSG changed while busy
    repeat (10) @(negedge clk);
    tx_accept(16'h0001); exp_q.push_back(16'h0001); exp_q.push_back(16'hFFFF);
    acc2 = -1; p1 = 1'bx; p2 = 1'bx;
    for (int k = 1; k < 600; k++) begin
      @(negedge clk);
      if (k == 1) tx_msg = 16'hFFFF;
      if (k == 21 * OSR + HALF + 1) p1 = txd;
      if (acc2 < 0 && tx_rdy) acc2 = k;
      if (acc2 >= 0 && k == acc2 + 1) tx_vld = 1'b0;
      if (acc2 >= 0 && k == acc2 + 21 * OSR + HALF + 1) p2 = txd;
      if (acc2 >= 0 && k == acc2 + 200) break;
    end
    check("b2b_period", 32'(acc2), 32'd193);
    check("b2b_par1", {31'd0, p1}, 32'd1);
    check("b2b_par2", {31'd0, p2}, 32'd0);
    expect_rx("b2b_first");
    expect_rx("b2b_second");

    // Parity error from the line model
    loop = 1'b0; e0 = err_seen; v0 = got_q.size();
    send_frame(16'h1234, 4, 1'b1, 1'b0);
    check("par_err_count", 32'(err_seen - e0), 32'd1);
    check("par_no_vld", 32'(got_q.size() - v0), 32'd0);
    check("par_msg_hold", {16'd0, rx_msg}, 32'h0000FFFF);

    // Timeout: line stuck high after the 5th data bit's mid-edge
    e0 = err_seen;
    rxd_m = 1'b0; repeat (2 * OSR) @(negedge clk);
    repeat (4) send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    repeat (4) send_bit(1'b1, 0);
    rxd_m = 1'b0; repeat (HALF) @(negedge clk);
    rxd_m = 1'b1;
    @(posedge clk);
    n = 0;
    while (!rx_err && n < 40) begin @(posedge clk); #1; n++; end
    check("tmo_latency", 32'(n), 32'd13);
    @(negedge clk); repeat (OSR) @(negedge clk);
    check("tmo_err_count", 32'(err_seen - e0), 32'd1);
    exp_q.push_back(16'h00FF);
    send_frame(16'h00FF, 4, 1'b0, 1'b0);
    expect_rx("after_tmo");

    // One-bit preamble is discarded silently
    e0 = err_seen; v0 = got_q.size();
    send_frame(16'h0000, 1, 1'b0, 1'b0);
    check("short_pre_no_err", 32'(err_seen - e0), 32'd0);
    check("short_pre_no_vld", 32'(got_q.size() - v0), 32'd0);

    // Mid-edges jittered by +/-1 clock
    exp_q.push_back(16'hC0DE);
    send_frame(16'hC0DE, 4, 1'b0, 1'b1);
    expect_rx("jitter");

    // Reset in the middle of a looped-back payload
    loop = 1'b1;
    repeat (10) @(negedge clk);
    tx_accept(16'h3C3C);
    @(negedge clk); tx_vld = 1'b0;
    e0 = err_seen; v0 = got_q.size();
    n = 1;
    while (n < 140 && !(n > 60 && txd)) begin @(negedge clk); n++; end
    check("rst_mid_txd_high", {31'd0, txd}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_txd", {31'd0, txd}, 32'd0);
    check("rst_mid_rdy", {31'd0, tx_rdy}, 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_rel_rdy", {31'd0, tx_rdy}, 32'd1);
    repeat (250) @(negedge clk);
    check("rst_no_err", 32'(err_seen - e0), 32'd0);
    check("rst_no_vld", 32'(got_q.size() - v0), 32'd0);
    tx_accept(16'h5A5A); exp_q.push_back(16'h5A5A);
    @(negedge clk); tx_vld = 1'b0;
    expect_rx("after_rst");

    repeat (20) @(negedge clk);
    check("never_both", 32'(both_seen), 32'd0);
    check("unexpected_rx", 32'(got_q.size()), 32'd0);
    check("missing_rx", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
